// File: rtl/output_store_controller.sv
// Packs output activation bytes from the PE array into little-endian 32-bit GLB words
// with per-byte write enables, starting at an arbitrary byte base address.
//
// state | meaning
// IDLE  | waiting for store_state_i to start a store
// PACK  | accepting bytes, emitting a word per filled lane 3 or final byte
// DONE  | one-cycle completion pulse
// HOLD  | store finished, waiting for store_state_i to drop before re-arming
module output_store_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        store_state_i,
    input  logic [1:0]  layer_type_i,
    input  logic [31:0] ofmap_GLB_base_addr_i,
    input  logic [7:0]  pe_data_i,
    input  logic        pe_valid_i,
    output logic        pe_ready_o,
    output logic        glb_write_en_o,
    output logic [31:0] glb_addr_o,
    output logic [3:0]  glb_byte_we_o,
    output logic [31:0] glb_write_data_o,
    output logic        store_done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_DONE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  byte_total;
    logic [5:0]  byte_cnt;
    logic [1:0]  lane;
    logic [31:0] word_addr;
    logic [31:0] pack_data;
    logic [3:0]  pack_we;

    logic [31:0] merged_data;
    logic [3:0]  merged_we;
    logic        last_byte;
    logic        word_done;

    // Depthwise and standard layers produce 10 output bytes, the others 32.
    function automatic logic [5:0] bytes_for_layer(input logic [1:0] layer_type);
        case (layer_type)
            2'd1, 2'd2: bytes_for_layer = 6'd10;
            default:    bytes_for_layer = 6'd32;
        endcase
    endfunction

    always_comb begin
        merged_data = pack_data | ({24'd0, pe_data_i} << {lane, 3'b000});
        merged_we   = pack_we | (4'b0001 << lane);
        last_byte   = (byte_cnt == (byte_total - 6'd1));
        word_done   = (lane == 2'd3) || last_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            byte_total       <= 6'd0;
            byte_cnt         <= 6'd0;
            lane             <= 2'd0;
            word_addr        <= 32'd0;
            pack_data        <= 32'd0;
            pack_we          <= 4'd0;
            pe_ready_o       <= 1'b0;
            glb_write_en_o   <= 1'b0;
            glb_addr_o       <= 32'd0;
            glb_byte_we_o    <= 4'd0;
            glb_write_data_o <= 32'd0;
            store_done_o     <= 1'b0;
        end else begin
            glb_write_en_o <= 1'b0;
            glb_byte_we_o  <= 4'd0;
            store_done_o   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (store_state_i) begin
                        byte_total <= bytes_for_layer(layer_type_i);
                        byte_cnt   <= 6'd0;
                        lane       <= ofmap_GLB_base_addr_i[1:0];
                        word_addr  <= {ofmap_GLB_base_addr_i[31:2], 2'b00};
                        pack_data  <= 32'd0;
                        pack_we    <= 4'd0;
                        pe_ready_o <= 1'b1;
                        state      <= S_PACK;
                    end
                end

                S_PACK: begin
                    if (!store_state_i) begin
                        // Abort: partial word is dropped without a strobe.
                        pack_data  <= 32'd0;
                        pack_we    <= 4'd0;
                        byte_cnt   <= 6'd0;
                        pe_ready_o <= 1'b0;
                        state      <= S_IDLE;
                    end else if (pe_valid_i) begin
                        byte_cnt <= byte_cnt + 6'd1;
                        if (word_done) begin
                            glb_write_en_o   <= 1'b1;
                            glb_addr_o       <= word_addr;
                            glb_byte_we_o    <= merged_we;
                            glb_write_data_o <= merged_data;
                            pack_data        <= 32'd0;
                            pack_we          <= 4'd0;
                            word_addr        <= word_addr + 32'd4;
                            lane             <= 2'd0;
                        end else begin
                            pack_data <= merged_data;
                            pack_we   <= merged_we;
                            lane      <= lane + 2'd1;
                        end
                        if (last_byte) begin
                            store_done_o <= 1'b1;
                            pe_ready_o   <= 1'b0;
                            state        <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    state <= store_state_i ? S_HOLD : S_IDLE;
                end

                S_HOLD: begin
                    if (!store_state_i) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
